jtcop_bac_rom_arb: RTL and testbench
====================================

JTCOP_BAC_ROM_ARB -- requirements
Module: jtcop_bac_rom_arb

Interface
REQ-001 The block SHALL have parameter AW, default 17, giving the client ROM word-address width.
REQ-002 The block SHALL have parameter MAW, default 19, giving the memory-side address width; MAW = AW+2.
REQ-003 clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 bac0_cs, bac1_cs, bac2_cs  input  1 each  client read request, held high while the client wants data.
REQ-006 bac0_addr, bac1_addr, bac2_addr  input  AW each  client word address.
REQ-007 bac0_data, bac1_data, bac2_data  output  16 each  cached read data per client.
REQ-008 bac0_ok, bac1_ok, bac2_ok  output  1 each  data valid for the current client address.
REQ-009 mem_req  output  1  memory read request, held until acknowledged.
REQ-010 mem_addr  output  MAW  memory address = {client index[1:0], client addr}.
REQ-011 mem_data  input  16  memory read data, valid when mem_dok is high.
REQ-012 mem_dok  input  1  one-cycle data-ready pulse from memory.

Function
REQ-013 The block SHALL keep, per client, a one-entry cache holding a tag (AW bits), data (16 bits) and a valid bit.
REQ-014 baN_ok SHALL be combinational: baN_cs AND validN AND (tagN == baN_addr).
REQ-015 baN_data SHALL always drive the cached data register of client N, whatever the state of ok.
REQ-016 A client is pending when cs is high and ok is low.
REQ-017 The FSM SHALL have two states, IDLE and WAIT.
REQ-018 In IDLE with at least one client pending, the block SHALL grant one client and move to WAIT.
REQ-019 On that same edge the block SHALL latch the client's address and index, and SHALL assert mem_req and mem_addr from registers.
REQ-020 In WAIT, mem_req and mem_addr SHALL hold constant until a cycle with mem_dok high.
REQ-021 On a mem_dok cycle in WAIT, the block SHALL on that edge write the latched address to the granted client's tag and mem_data to its data, set valid, clear mem_req and return to IDLE.
REQ-022 The latency rule is: with cs and a new address at cycle N in IDLE, mem_req SHALL be high at N+1; mem_dok at cycle M gives ok high at M+1 if the address is unchanged.
REQ-023 The minimum gap between two memory requests SHALL be one IDLE cycle.
REQ-024 If cs drops or the address changes during WAIT, the transaction SHALL still complete and fill the cache with the latched address; ok then follows REQ-014, and the client is re-requested if it still misses.
REQ-025 mem_dok while in IDLE SHALL be ignored.
REQ-026 A mem_dok arriving on the same edge that a client changes address SHALL fill the cache with the old tag, so ok stays low.
REQ-027 Default arbitration SHALL be round-robin: the search starts at the client after the last granted one, order 0->1->2->0.
REQ-028 The last-granted pointer SHALL update only on a grant.

Reset
REQ-029 While rst is low, the block SHALL force state IDLE, mem_req=0, mem_addr=0, all valid=0, all tags and data=0, and the last-granted pointer=2, so client 0 is searched first.
REQ-030 Reset asserted in WAIT SHALL abandon the transaction; a mem_dok after reset release SHALL be ignored per REQ-025.
REQ-031 All baN_ok SHALL be 0 from the first cycle rst is sampled low.

Configuration
REQ-032 When macro JTCOP_ROMARB_FIXPRIO_EN is defined, arbitration SHALL be fixed priority 0 > 1 > 2 and the last-granted pointer SHALL be removed.
REQ-033 When JTCOP_ROMARB_FIXPRIO_EN is undefined, round-robin per REQ-027 SHALL apply.

Verification
REQ-034 Reset then bac0_cs=1 with addr=0x00123: mem_req rises one cycle later with mem_addr=0x00123; mem_dok with data 0xBEEF gives bac0_ok=1 and bac0_data=0xBEEF on the next cycle.
REQ-035 Repeat the same bac0 address 0x00123 after the fill: bac0_ok is high immediately and no new mem_req appears.
REQ-036 All three clients pending from reset with mem_dok returned 3 cycles after each request: grant order 0,1,2 with mem_addr top bits 00,01,10; with JTCOP_ROMARB_FIXPRIO_EN and client 0 re-missing each time, client 0 starves clients 1 and 2.
REQ-037 bac1 changes address from 0x00010 to 0x00020 during WAIT: the fill tags 0x00010, bac1_ok stays 0, and a second request for {01,0x00020} follows.
REQ-038 rst low for one cycle during WAIT, then a stray mem_dok: mem_req=0, no cache fill, all ok=0, and the next request is serviced normally.
REQ-039 bac2_cs drops during WAIT: the transaction completes, bac2_ok=0 while cs is low, and bac2_ok=1 without a new request when cs rises again with the same address.

Source files
------------

// File: rtl/jtcop_bac_rom_arb_if.sv
// rtl/jtcop_bac_rom_arb_if.sv - client/memory signal bundle for the BAC ROM arbiter
interface jtcop_bac_rom_arb_if #(
    parameter int AW  = 17,
    parameter int MAW = 19
);
    logic          bac0_cs,   bac1_cs,   bac2_cs;
    logic [AW-1:0] bac0_addr, bac1_addr, bac2_addr;
    logic [15:0]   bac0_data, bac1_data, bac2_data;
    logic          bac0_ok,   bac1_ok,   bac2_ok;
    logic          mem_req;
    logic [MAW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_dok;

    // Arbiter side
    modport slave (
        input  bac0_cs, bac1_cs, bac2_cs,
        input  bac0_addr, bac1_addr, bac2_addr,
        output bac0_data, bac1_data, bac2_data,
        output bac0_ok, bac1_ok, bac2_ok,
        output mem_req, mem_addr,
        input  mem_data, mem_dok
    );

    // Clients and memory model side
    modport master (
        output bac0_cs, bac1_cs, bac2_cs,
        output bac0_addr, bac1_addr, bac2_addr,
        input  bac0_data, bac1_data, bac2_data,
        input  bac0_ok, bac1_ok, bac2_ok,
        input  mem_req, mem_addr,
        output mem_data, mem_dok
    );
endinterface

// File: rtl/jtcop_bac_rom_arb.sv
// rtl/jtcop_bac_rom_arb.sv - three-client ROM arbiter with one-entry caches; JTCOP_ROMARB_FIXPRIO_EN selects fixed priority
module jtcop_bac_rom_arb #(
    parameter int AW  = 17,
    parameter int MAW = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    jtcop_bac_rom_arb_if.slave    bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [2:0]     cs;
    logic [AW-1:0]  addr [3];
    logic [2:0]     ok;
    logic [2:0]     pend;

    state_t         state_q, state_d;
    logic [AW-1:0]  tag_q [3];
    logic [AW-1:0]  tag_d [3];
    logic [15:0]    data_q [3];
    logic [15:0]    data_d [3];
    logic [2:0]     valid_q, valid_d;
    logic           req_q, req_d;
    logic [MAW-1:0] maddr_q, maddr_d;
    logic [1:0]     gidx_q, gidx_d;
`ifndef JTCOP_ROMARB_FIXPRIO_EN
    logic [1:0]     last_q, last_d;
`endif

    logic [1:0]     o0, o1, o2, sel;

    assign cs      = {bus.bac2_cs, bus.bac1_cs, bus.bac0_cs};
    assign addr[0] = bus.bac0_addr;
    assign addr[1] = bus.bac1_addr;
    assign addr[2] = bus.bac2_addr;

    // Cache hit per client; a client that misses while selected is pending
    always_comb begin
        ok = '0;
        for (int n = 0; n < 3; n++) begin
            ok[n] = cs[n] & valid_q[n] & (tag_q[n] == addr[n]);
        end
        pend = cs & ~ok;
    end

    // Search order: fixed 0,1,2 or rotating from the client after the last grant
    always_comb begin
`ifdef JTCOP_ROMARB_FIXPRIO_EN
        o0 = 2'd0; o1 = 2'd1; o2 = 2'd2;
`else
        case (last_q)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
`endif
        if (pend[o0])      sel = o0;
        else if (pend[o1]) sel = o1;
        else               sel = o2;
    end

    // Grant in IDLE, fill the granted client's cache entry on mem_dok in WAIT
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        req_d   = req_q;
        maddr_d = maddr_q;
        gidx_d  = gidx_q;
`ifndef JTCOP_ROMARB_FIXPRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|pend) begin
                    state_d = ST_WAIT;
                    gidx_d  = sel;
                    maddr_d = {sel, addr[sel]};
                    req_d   = 1'b1;
`ifndef JTCOP_ROMARB_FIXPRIO_EN
                    last_d  = sel;
`endif
                end
            end
            ST_WAIT: begin
                // The latched address is the tag, even if the client moved on meanwhile
                if (bus.mem_dok) begin
                    tag_d[gidx_q]   = maddr_q[AW-1:0];
                    data_d[gidx_q]  = bus.mem_data;
                    valid_d[gidx_q] = 1'b1;
                    req_d           = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and cache registers; reset abandons any outstanding transaction
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            req_q   <= 1'b0;
            maddr_q <= '0;
            gidx_q  <= '0;
            for (int n = 0; n < 3; n++) begin
                tag_q[n]  <= '0;
                data_q[n] <= '0;
            end
`ifndef JTCOP_ROMARB_FIXPRIO_EN
            last_q  <= 2'd2;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            maddr_q <= maddr_d;
            gidx_q  <= gidx_d;
            for (int n = 0; n < 3; n++) begin
                tag_q[n]  <= tag_d[n];
                data_q[n] <= data_d[n];
            end
`ifndef JTCOP_ROMARB_FIXPRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.bac0_ok   = ok[0];
    assign bus.bac1_ok   = ok[1];
    assign bus.bac2_ok   = ok[2];
    assign bus.bac0_data = data_q[0];
    assign bus.bac1_data = data_q[1];
    assign bus.bac2_data = data_q[2];
    assign bus.mem_req   = req_q;
    assign bus.mem_addr  = maddr_q;
endmodule

// File: tb/tb_jtcop_bac_rom_arb.sv
// tb/tb_jtcop_bac_rom_arb.sv - self-checking bench for jtcop_bac_rom_arb
module tb_jtcop_bac_rom_arb;
    localparam int AW  = 17;
    localparam int MAW = 19;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jtcop_bac_rom_arb_if #(.AW(AW), .MAW(MAW)) bus ();
    jtcop_bac_rom_arb #(.AW(AW), .MAW(MAW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    logic [MAW-1:0] exp_q [$];

    typedef struct {
        int             c;
        logic [AW-1:0]  a;
        logic [15:0]    d;
        logic [MAW-1:0] em;
    } vec_t;
    vec_t vt [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_client(input int c, input logic cs, input logic [AW-1:0] a);
        case (c)
            0: begin bus.bac0_cs = cs; bus.bac0_addr = a; end
            1: begin bus.bac1_cs = cs; bus.bac1_addr = a; end
            default: begin bus.bac2_cs = cs; bus.bac2_addr = a; end
        endcase
    endtask

    function automatic logic get_ok(input int c);
        case (c)
            0: return bus.bac0_ok;
            1: return bus.bac1_ok;
            default: return bus.bac2_ok;
        endcase
    endfunction

    function automatic logic [15:0] get_data(input int c);
        case (c)
            0: return bus.bac0_data;
            1: return bus.bac1_data;
            default: return bus.bac2_data;
        endcase
    endfunction

    // Wait (bounded) for mem_req, then compare mem_addr with the scoreboard head
    task automatic expect_req(input string name, output int waited, output logic [MAW-1:0] cur);
        cur = '0;
        @(negedge clk);
        waited = 1;
        while (!bus.mem_req && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s_req", name), bus.mem_req, 1);
        if (exp_q.size() == 0) begin
            check($sformatf("%s_sb_empty", name), 1, 0);
        end else begin
            cur = exp_q.pop_front();
            check($sformatf("%s_addr", name), bus.mem_addr, cur);
        end
    endtask

    task automatic hold_req(input string name, input int n, input logic [MAW-1:0] a);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_hold_req", name), bus.mem_req, 1);
            check($sformatf("%s_hold_addr", name), bus.mem_addr, a);
        end
    endtask

    task automatic pulse_dok(input logic [15:0] d);
        bus.mem_dok  = 1'b1;
        bus.mem_data = d;
        @(negedge clk);
        bus.mem_dok  = 1'b0;
        bus.mem_data = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) set_client(c, 1'b0, '0);
        bus.mem_dok  = 1'b0;
        bus.mem_data = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        logic [MAW-1:0] cur;
        logic [MAW-1:0] rr_exp [4];
        logic [AW-1:0] a0;

        vt[0] = '{0, 17'h00123, 16'hBEEF, 19'h00123};
        vt[1] = '{1, 17'h1ABCD, 16'h1234, 19'h3ABCD};
        vt[2] = '{2, 17'h00001, 16'h5A5A, 19'h40001};
        vt[3] = '{0, 17'h1FFFF, 16'hFFFF, 19'h1FFFF};

        // Reset state
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req", bus.mem_req, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_ok", {bus.bac2_ok, bus.bac1_ok, bus.bac0_ok}, 0);
        check("rst_data0", bus.bac0_data, 0);
        check("rst_data2", bus.bac2_data, 0);
        rst = 1'b1;

        // Table: single-client miss, fill, then hit without a new request
        for (int i = 0; i < 4; i++) begin
            set_client(vt[i].c, 1'b1, vt[i].a);
            exp_q.push_back(vt[i].em);
            #1 check($sformatf("v%0d_miss", i), get_ok(vt[i].c), 0);
            expect_req($sformatf("v%0d", i), w, cur);
            check($sformatf("v%0d_latency", i), w, 1);
            hold_req($sformatf("v%0d", i), 2, cur);
            pulse_dok(vt[i].d);
            check($sformatf("v%0d_ok", i), get_ok(vt[i].c), 1);
            check($sformatf("v%0d_data", i), get_data(vt[i].c), vt[i].d);
            check($sformatf("v%0d_req_low", i), bus.mem_req, 0);
            @(negedge clk);
            check($sformatf("v%0d_hit_noreq", i), bus.mem_req, 0);
            check($sformatf("v%0d_hit_ok", i), get_ok(vt[i].c), 1);
            set_client(vt[i].c, 1'b0, vt[i].a);
            #1 check($sformatf("v%0d_cs_off_ok", i), get_ok(vt[i].c), 0);
            check($sformatf("v%0d_data_kept", i), get_data(vt[i].c), vt[i].d);
        end

        // Arbitration: all three pending, client 0 re-misses after every fill
        do_reset();
`ifdef JTCOP_ROMARB_FIXPRIO_EN
        rr_exp = '{19'h00100, 19'h00101, 19'h00102, 19'h00103};
`else
        rr_exp = '{19'h00100, 19'h20200, 19'h40300, 19'h00101};
`endif
        a0 = 17'h00100;
        set_client(0, 1'b1, a0);
        set_client(1, 1'b1, 17'h00200);
        set_client(2, 1'b1, 17'h00300);
        for (int g = 0; g < 4; g++) exp_q.push_back(rr_exp[g]);
        for (int g = 0; g < 4; g++) begin
            expect_req($sformatf("arb%0d", g), w, cur);
            check($sformatf("arb%0d_latency", g), w, 1);
            hold_req($sformatf("arb%0d", g), 2, cur);
            if (rr_exp[g][MAW-1:AW] == 2'd0) begin
                a0 = a0 + 17'd1;
                set_client(0, 1'b1, a0);
                pulse_dok(16'h1000 + 16'(g));
                check($sformatf("arb%0d_oldtag_ok0", g), bus.bac0_ok, 0);
            end else begin
                pulse_dok(16'h1000 + 16'(g));
                check($sformatf("arb%0d_ok", g), get_ok(int'(rr_exp[g][MAW-1:AW])), 1);
                check($sformatf("arb%0d_data", g), get_data(int'(rr_exp[g][MAW-1:AW])), 16'h1000 + 16'(g));
            end
            check($sformatf("arb%0d_gap", g), bus.mem_req, 0);
        end
        for (int c = 0; c < 3; c++) set_client(c, 1'b0, '0);
        @(negedge clk);

        // bac1 changes address during WAIT: old tag filled, then re-request
        set_client(1, 1'b1, 17'h00010);
        exp_q.push_back(19'h20010);
        expect_req("chg1", w, cur);
        @(negedge clk);
        set_client(1, 1'b1, 17'h00020);
        exp_q.push_back(19'h20020);
        hold_req("chg1", 1, cur);
        pulse_dok(16'hAAAA);
        check("chg1_ok_low", bus.bac1_ok, 0);
        check("chg1_gap", bus.mem_req, 0);
        expect_req("chg2", w, cur);
        check("chg2_latency", w, 1);
        hold_req("chg2", 1, cur);
        pulse_dok(16'hBBBB);
        check("chg2_ok", bus.bac1_ok, 1);
        check("chg2_data", bus.bac1_data, 16'hBBBB);
        set_client(1, 1'b0, 17'h00020);

        // Reset pulse during WAIT, then a stray mem_dok
        set_client(2, 1'b1, 17'h00077);
        exp_q.push_back(19'h40077);
        expect_req("rw", w, cur);
        rst = 1'b0;
        @(negedge clk);
        check("rw_req", bus.mem_req, 0);
        check("rw_addr", bus.mem_addr, 0);
        check("rw_ok", {bus.bac2_ok, bus.bac1_ok, bus.bac0_ok}, 0);
        check("rw_data1", bus.bac1_data, 0);
        rst = 1'b1;
        set_client(2, 1'b0, 17'h00077);
        pulse_dok(16'hDEAD);
        check("stray_req", bus.mem_req, 0);
        check("stray_data2", bus.bac2_data, 0);
        set_client(2, 1'b1, 17'h00077);
        #1 check("stray_ok2", bus.bac2_ok, 0);
        exp_q.push_back(19'h40077);
        expect_req("post_rst", w, cur);
        check("post_rst_latency", w, 1);
        hold_req("post_rst", 1, cur);
        pulse_dok(16'h7777);
        check("post_rst_ok", bus.bac2_ok, 1);
        check("post_rst_data", bus.bac2_data, 16'h7777);

        // bac2 drops cs during WAIT, returns later with the same address
        set_client(2, 1'b1, 17'h00055);
        @(negedge clk);
        exp_q.push_back(19'h40055);
        expect_req("drop", w, cur);
        set_client(2, 1'b0, 17'h00055);
        hold_req("drop", 1, cur);
        pulse_dok(16'h5555);
        check("drop_ok_low", bus.bac2_ok, 0);
        check("drop_req_low", bus.mem_req, 0);
        @(negedge clk);
        check("drop_no_rereq", bus.mem_req, 0);
        set_client(2, 1'b1, 17'h00055);
        #1 check("drop_ok_back", bus.bac2_ok, 1);
        check("drop_data", bus.bac2_data, 16'h5555);
        @(negedge clk);
        check("drop_hit_noreq", bus.mem_req, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
